// File: rtl/gray_seq_pkg.sv
// Shared types and helpers for the Gray decade sequencer: FSM states,
// the decimal-to-Gray map of the decoder, and the expected one-hot feedback.
package gray_seq_pkg;

    typedef enum logic [2:0] {
        IDLE,
        STEP,
        SETTLE,
        CHECK,
        FIN
    } seq_state_t;

    localparam logic [3:0] DIGIT_MAX = 4'd9;

    // Adjacent digits differ in exactly one bit, so a one-digit walk is glitch free.
    function automatic logic [3:0] dec2gray(input logic [3:0] dig);
        logic [3:0] g;
        case (dig)
            4'd0:    g = 4'b0000;
            4'd1:    g = 4'b0001;
            4'd2:    g = 4'b0011;
            4'd3:    g = 4'b0010;
            4'd4:    g = 4'b0110;
            4'd5:    g = 4'b0111;
            4'd6:    g = 4'b0101;
            4'd7:    g = 4'b0100;
            4'd8:    g = 4'b1100;
            4'd9:    g = 4'b1101;
            default: g = 4'b0000;
        endcase
        return g;
    endfunction

    function automatic logic [9:0] onehot10(input logic [3:0] dig);
        logic [9:0] oh;
        oh = '0;
        if (dig <= DIGIT_MAX) begin
            oh = 10'd1 << dig;
        end
        return oh;
    endfunction

endpackage

// File: rtl/gray_step_prescaler.sv
// Divides the clock into digit steps: tick marks the last cycle of each
// STEP_DIV-cycle interval while enabled.
module gray_step_prescaler #(
    parameter int STEP_DIV = 4
) (
    input  logic CLK,
    input  logic RST,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam int CNT_W = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam logic [CNT_W-1:0] TERM = CNT_W'(STEP_DIV - 1);

    logic [CNT_W-1:0] cnt;

    assign tick = en && (cnt == TERM);

    always_ff @(posedge CLK) begin
        if (RST || clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= tick ? '0 : cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/gray_decade_sequencer.sv
// Walks the Gray decoder input one digit at a time toward a requested digit,
// waits for it to settle, then checks the decoder's one-hot feedback.
module gray_decade_sequencer
    import gray_seq_pkg::*;
#(
    parameter int STEP_DIV   = 4,
    parameter int SETTLE_CYC = 2
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       REQ_VALID,
    output logic       REQ_READY,
    input  logic [3:0] TARGET,
    input  logic [9:0] Y_FB,
    output logic       D,
    output logic       C,
    output logic       B,
    output logic       A,
    output logic       BUSY,
    output logic       DONE,
    output logic       ERR,
    output logic       MISMATCH
);

    localparam int SW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
    localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYC - 1);

    seq_state_t state, state_nx;
    logic [3:0] pos, pos_nx, tgt;
    logic [3:0] dcba;
    logic       dir_up;
    logic [SW-1:0] settle_cnt;
    logic       err_q, mism_q;
    logic       accept, legal, tick;

    assign accept = (state == IDLE) && REQ_VALID;
    assign legal  = (TARGET <= DIGIT_MAX);
    assign pos_nx = dir_up ? pos + 4'd1 : pos - 4'd1;

    gray_step_prescaler #(
        .STEP_DIV(STEP_DIV)
    ) u_prescaler (
        .CLK (CLK),
        .RST (RST),
        .clr (accept),
        .en  (state == STEP),
        .tick(tick)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (REQ_VALID && legal) state_nx = (TARGET == pos) ? SETTLE : STEP;
            STEP:    if (tick && (pos_nx == tgt)) state_nx = SETTLE;
            SETTLE:  if (settle_cnt == SETTLE_LAST) state_nx = CHECK;
            CHECK:   state_nx = FIN;
            FIN:     state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Request target and direction are only meaningful after an accept.
    always_ff @(posedge CLK) begin
        if (accept && legal) begin
            tgt    <= TARGET;
            dir_up <= (TARGET > pos);
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            pos        <= 4'd0;
            dcba       <= 4'b0000;
            settle_cnt <= '0;
            err_q      <= 1'b0;
            mism_q     <= 1'b0;
        end else begin
            err_q      <= accept && !legal;
            settle_cnt <= (state == SETTLE) ? settle_cnt + SW'(1) : '0;
            if (accept && legal) begin
                mism_q <= 1'b0;
            end else if ((state == CHECK) && (Y_FB != onehot10(pos))) begin
                mism_q <= 1'b1;
            end
            if ((state == STEP) && tick) begin
                pos  <= pos_nx;
                dcba <= dec2gray(pos_nx);
            end
        end
    end

    assign {D, C, B, A} = dcba;
    assign REQ_READY    = (state == IDLE);
    assign BUSY         = (state != IDLE);
    assign DONE         = (state == FIN);
    assign ERR          = err_q;
    assign MISMATCH     = mism_q;

endmodule

// File: tb/tb_gray_decade_sequencer.sv
// Directed bench: a fast instance (STEP_DIV=1) and a slow one (STEP_DIV=4),
// each fed by a behavioural Gray decoder whose feedback can be forced to zero.
module tb_gray_decade_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] req_valid, req_ready, d_o, c_o, b_o, a_o, busy, done, err, mism, fb_zero;
    logic [3:0] target [2];
    logic [9:0] y_fb [2];

    int n_checks = 0;
    int n_errors = 0;

    logic [3:0] hist [0:63];
    int r_lat, r_done, r_err, r_chg, r_bad;
    logic r_err_k1, r_rdy_k1, r_mism_k1, r_mism_done;

    always #5 clk = ~clk;

    gray_decade_sequencer #(.STEP_DIV(1), .SETTLE_CYC(2)) u_fast (
        .CLK(clk), .RST(rst), .REQ_VALID(req_valid[0]), .REQ_READY(req_ready[0]),
        .TARGET(target[0]), .Y_FB(y_fb[0]), .D(d_o[0]), .C(c_o[0]), .B(b_o[0]), .A(a_o[0]),
        .BUSY(busy[0]), .DONE(done[0]), .ERR(err[0]), .MISMATCH(mism[0])
    );

    gray_decade_sequencer #(.STEP_DIV(4), .SETTLE_CYC(2)) u_slow (
        .CLK(clk), .RST(rst), .REQ_VALID(req_valid[1]), .REQ_READY(req_ready[1]),
        .TARGET(target[1]), .Y_FB(y_fb[1]), .D(d_o[1]), .C(c_o[1]), .B(b_o[1]), .A(a_o[1]),
        .BUSY(busy[1]), .DONE(done[1]), .ERR(err[1]), .MISMATCH(mism[1])
    );

    function automatic logic [9:0] decode(input logic [3:0] g);
        case (g)
            4'b0000: return 10'h001;
            4'b0001: return 10'h002;
            4'b0011: return 10'h004;
            4'b0010: return 10'h008;
            4'b0110: return 10'h010;
            4'b0111: return 10'h020;
            4'b0101: return 10'h040;
            4'b0100: return 10'h080;
            4'b1100: return 10'h100;
            4'b1101: return 10'h200;
            default: return 10'h000;
        endcase
    endfunction

    function automatic logic [3:0] gray_of(input int n);
        case (n)
            0: return 4'b0000;  1: return 4'b0001;  2: return 4'b0011;
            3: return 4'b0010;  4: return 4'b0110;  5: return 4'b0111;
            6: return 4'b0101;  7: return 4'b0100;  8: return 4'b1100;
            9: return 4'b1101;
            default: return 4'bxxxx;
        endcase
    endfunction

    function automatic logic [3:0] dcba_of(input int i);
        return {d_o[i], c_o[i], b_o[i], a_o[i]};
    endfunction

    always_comb begin
        y_fb[0] = fb_zero[0] ? 10'h000 : decode(dcba_of(0));
        y_fb[1] = fb_zero[1] ? 10'h000 : decode(dcba_of(1));
    end

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Issues one request and watches max_cyc negedges after the accept edge.
    task automatic do_req(input int idx, input logic [3:0] tgt, input int max_cyc);
        logic [3:0] prev, cur;
        @(negedge clk);
        hist[0] = dcba_of(idx);
        req_valid[idx] = 1'b1;
        target[idx] = tgt;
        @(negedge clk);
        req_valid[idx] = 1'b0;
        r_lat = -1; r_done = 0; r_err = 0; r_chg = 0; r_bad = 0;
        r_err_k1 = err[idx]; r_rdy_k1 = req_ready[idx]; r_mism_k1 = mism[idx];
        r_mism_done = 1'b0;
        prev = hist[0];
        for (int k = 1; k <= max_cyc; k++) begin
            if (k > 1) @(negedge clk);
            cur = dcba_of(idx);
            hist[k] = cur;
            if (cur != prev) begin
                r_chg++;
                if ($countones(cur ^ prev) != 1) r_bad++;
            end
            prev = cur;
            if (done[idx]) begin
                r_done++;
                if (r_lat < 0) begin
                    r_lat = k - 1;
                    r_mism_done = mism[idx];
                end
            end
            if (err[idx]) r_err++;
        end
    endtask

    initial begin
        int cnt;
        rst = 1'b1;
        req_valid = '0;
        fb_zero = '0;
        target[0] = 4'd0;
        target[1] = 4'd0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Reset state
        check("rst_dcba", dcba_of(0), 0);
        check("rst_ready", req_ready[0], 1);
        check("rst_busy", busy[0], 0);
        check("rst_done", done[0], 0);
        check("rst_err", err[0], 0);
        check("rst_mism", mism[0], 0);

        // Fast walk 0 -> 9
        do_req(0, 4'd9, 16);
        check("up_lat", r_lat, 12);
        check("up_chg", r_chg, 9);
        check("up_onebit", r_bad, 0);
        check("up_done_cnt", r_done, 1);
        check("up_err", r_err, 0);
        check("up_mism", r_mism_done, 0);
        check("up_busy_k1", r_rdy_k1, 0);
        for (int k = 2; k <= 10; k++) check($sformatf("up_dcba_%0d", k), hist[k], gray_of(k - 1));

        // Slow: climb to 9, then walk down to 4 with a change every 4 cycles
        do_req(1, 4'd9, 44);
        check("slow_up_lat", r_lat, 39);
        check("slow_up_end", dcba_of(1), 4'b1101);
        do_req(1, 4'd4, 30);
        check("dn_lat", r_lat, 23);
        check("dn_chg", r_chg, 5);
        check("dn_onebit", r_bad, 0);
        for (int j = 1; j <= 5; j++) begin
            check($sformatf("dn_hold_%0d", j), hist[4*j], gray_of(10 - j));
            check($sformatf("dn_step_%0d", j), hist[4*j + 1], gray_of(9 - j));
        end
        check("dn_end", dcba_of(1), 4'b0110);

        // Illegal target
        do_req(0, 4'd12, 6);
        check("ill_err_k1", r_err_k1, 1);
        check("ill_err_cnt", r_err, 1);
        check("ill_done", r_done, 0);
        check("ill_chg", r_chg, 0);
        check("ill_ready", r_rdy_k1, 1);

        // Redundant target
        do_req(0, 4'd9, 8);
        check("same_lat", r_lat, 3);
        check("same_chg", r_chg, 0);
        check("same_done", r_done, 1);

        // Feedback fault on a walk 9 -> 5
        fb_zero[0] = 1'b1;
        do_req(0, 4'd5, 12);
        check("flt_lat", r_lat, 7);
        check("flt_mism_k1", r_mism_k1, 0);
        check("flt_mism_done", r_mism_done, 1);
        check("flt_end", dcba_of(0), 4'b0111);
        fb_zero[0] = 1'b0;
        repeat (3) @(negedge clk);
        check("flt_sticky", mism[0], 1);
        do_req(0, 4'd15, 4);
        check("flt_ill_keep", mism[0], 1);
        check("flt_ill_err", r_err, 1);
        do_req(0, 4'd5, 8);
        check("flt_clr_k1", r_mism_k1, 0);
        check("flt_clr_done", r_mism_done, 0);

        // Reset mid-walk at pos 3 (walking 5 -> 0)
        @(negedge clk);
        req_valid[0] = 1'b1;
        target[0] = 4'd0;
        @(negedge clk);
        req_valid[0] = 1'b0;
        repeat (2) @(negedge clk);
        check("mid_pos3", dcba_of(0), 4'b0010);
        rst = 1'b1;
        @(negedge clk);
        check("mid_dcba", dcba_of(0), 0);
        check("mid_ready", req_ready[0], 1);
        check("mid_busy", busy[0], 0);
        rst = 1'b0;
        cnt = 0;
        for (int k = 0; k < 15; k++) begin
            if (done[0]) cnt++;
            @(negedge clk);
        end
        check("mid_no_done", cnt, 0);
        check("mid_hold", dcba_of(0), 0);

        // REQ_VALID while busy is ignored
        req_valid[0] = 1'b1;
        target[0] = 4'd2;
        @(negedge clk);
        req_valid[0] = 1'b0;
        @(negedge clk);
        check("bsy_busy", busy[0], 1);
        check("bsy_ready", req_ready[0], 0);
        req_valid[0] = 1'b1;
        target[0] = 4'd7;
        @(negedge clk);
        req_valid[0] = 1'b0;
        cnt = 0;
        for (int k = 0; k < 20; k++) begin
            if (done[0]) cnt++;
            @(negedge clk);
        end
        check("bsy_done_cnt", cnt, 1);
        check("bsy_end", dcba_of(0), 4'b0011);
        check("bsy_ready_end", req_ready[0], 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
